// File: rtl/pulse_monitor.sv
// pulse_monitor: measures high pulses on y_in, counts well-formed ones and flags malformed traffic
module pulse_monitor #(
   parameter int CNT_W     = 8,
   parameter int PULSE_LEN = 3,
   parameter int MIN_GAP   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             y_in,
   input  logic             clear_in,
   output logic [CNT_W-1:0] count_out,
   output logic             done_out,
   output logic             err_out,
   output logic             busy_out
);
   typedef enum logic [1:0] {IDLE, MEAS, GAP} state_t;
   state_t state_q, state_d;
   logic [2:0] wcnt_q, wcnt_d, gcnt_q, gcnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic pulse_end, valid, err_ev;
   // state, counters and registered outputs; reset discards any pulse in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         gcnt_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         gcnt_q  <= gcnt_d;
         count_q <= count_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end
   // next state: width counter runs in MEAS, gap counter in GAP, both saturate at 7
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         IDLE: if (y_in) begin
            state_d = MEAS;
            wcnt_d  = 3'd1;
         end
         MEAS: if (y_in) wcnt_d = (wcnt_q == 3'd7) ? wcnt_q : wcnt_q + 3'd1;
         else begin
            state_d = GAP;
            gcnt_d  = 3'd1;
         end
         GAP: if (y_in) begin
            state_d = MEAS;
            wcnt_d  = 3'd1;
         end else begin
            gcnt_d  = (gcnt_q == 3'd7) ? gcnt_q : gcnt_q + 3'd1;
            state_d = (gcnt_d >= 3'(MIN_GAP)) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
   end
   // outputs: pulse evaluation at the falling edge of y_in; clear beats any coincident event
   always_comb begin
      pulse_end = (state_q == MEAS) && !y_in;
      valid     = pulse_end && (wcnt_q == 3'(PULSE_LEN));
      err_ev    = (pulse_end && !valid) || ((state_q == GAP) && y_in && (gcnt_q < 3'(MIN_GAP)));
      count_d   = clear_in ? '0 : (valid && count_q != '1) ? count_q + CNT_W'(1) : count_q;
      done_d    = valid && !clear_in;
      err_d     = !clear_in && (err_q || err_ev);
      busy_d    = state_d != IDLE;
   end
   assign count_out = count_q;
   assign done_out  = done_q;
   assign err_out   = err_q;
   assign busy_out  = busy_q;
endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: directed vector table plus corner-case sequences for pulse_monitor
module tb_pulse_monitor;
   typedef struct {
      logic       rst;
      logic       y;
      logic       clr;
      logic [7:0] cnt;
      logic [1:0] cnt2;
      logic       done;
      logic       err;
      logic       busy;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1, y_in = 1'b0, clear_in = 1'b0;
   logic [7:0] count_out;
   logic [1:0] count2_out;
   logic done_out, err_out, busy_out, done2_out, err2_out, busy2_out;
   int checks = 0, failures = 0;
   vec_t tbl[$];
   always #5 clk = ~clk;
   pulse_monitor dut (
      .clk(clk), .reset(reset), .y_in(y_in), .clear_in(clear_in),
      .count_out(count_out), .done_out(done_out), .err_out(err_out), .busy_out(busy_out)
   );
   pulse_monitor #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .y_in(y_in), .clear_in(clear_in),
      .count_out(count2_out), .done_out(done2_out), .err_out(err2_out), .busy_out(busy2_out)
   );
   task automatic add(input logic r, y, c, input logic [7:0] ec, input logic [1:0] ec2, input logic ed, ee, eb);
      vec_t v;
      v.rst = r; v.y = y; v.clr = c; v.cnt = ec; v.cnt2 = ec2; v.done = ed; v.err = ee; v.busy = eb;
      tbl.push_back(v);
   endtask
   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic step(input vec_t v, input string nm);
      @(negedge clk);
      reset = v.rst; y_in = v.y; clear_in = v.clr;
      @(posedge clk);
      #1;
      chk({nm, ".count"}, count_out, v.cnt);
      chk({nm, ".count2"}, count2_out, v.cnt2);
      chk({nm, ".done"}, done_out, v.done);
      chk({nm, ".err"}, err_out, v.err);
      chk({nm, ".busy"}, busy_out, v.busy);
   endtask
   task automatic pulse(input int k, input logic clr_end, input logic e);
      int c2 = (k > 3) ? 3 : k;
      int n2 = (k + 1 > 3) ? 3 : k + 1;
      for (int i = 0; i < 3; i++) add(0, 1, 0, 8'(k), 2'(c2), 0, e, 1);
      if (clr_end) begin
         add(0, 0, 1, 0, 0, 0, 0, 1);
         add(0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
         add(0, 0, 0, 8'(k + 1), 2'(n2), 1, e, 1);
         add(0, 0, 0, 8'(k + 1), 2'(n2), 0, e, 0);
      end
   endtask
   initial begin
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 1, 1, 1, 0, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0);
      add(0, 1, 0, 1, 1, 0, 0, 1);
      add(0, 1, 0, 1, 1, 0, 0, 1);
      add(0, 0, 0, 1, 1, 0, 1, 1);
      add(0, 0, 0, 1, 1, 0, 1, 0);
      add(0, 0, 0, 1, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, 0, 1, 1);
      add(0, 0, 0, 1, 1, 0, 1, 1);
      add(0, 0, 0, 1, 1, 0, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 1, 1, 1, 0, 1);
      add(0, 1, 0, 1, 1, 0, 1, 1);
      add(0, 1, 0, 1, 1, 0, 1, 1);
      add(0, 1, 0, 1, 1, 0, 1, 1);
      add(0, 0, 0, 2, 2, 1, 1, 1);
      add(0, 0, 0, 2, 2, 0, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) pulse(k, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) pulse(k, 0, 0);
      pulse(4, 1, 0);
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));
      begin
         vec_t v;
         v = '{rst:0, y:1, clr:0, cnt:0, cnt2:0, done:0, err:0, busy:1};
         step(v, "mid_a");
         step(v, "mid_b");
         v.rst = 1;  v.busy = 0;
         step(v, "mid_rst");
         v.rst = 0;  v.busy = 1;
         step(v, "rel_1");
         step(v, "rel_2");
         step(v, "rel_3");
         v.y = 0; v.cnt = 1; v.cnt2 = 1; v.done = 1;
         step(v, "rel_end");
         v.done = 0; v.busy = 0;
         step(v, "rel_idle");
         v.y = 1; v.busy = 1;
         step(v, "w1_hi");
         v.y = 0; v.clr = 1; v.cnt = 0; v.cnt2 = 0;
         step(v, "clr_err");
         v.clr = 0; v.busy = 0;
         step(v, "clr_err_idle");
         v.y = 1; v.busy = 1;
         step(v, "gap_a");
         v.y = 0; v.err = 1;
         step(v, "short_end");
         v.y = 1;
         step(v, "gap_hit");
         v.y = 0; v.clr = 1; v.err = 0;
         step(v, "clr_gap");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of valid-pulse counter.
REQ-002 SHALL have parameter PULSE_LEN, default 3, required pulse width in clock cycles (range 1..6).
REQ-003 SHALL have parameter MIN_GAP, default 2, minimum low cycles between pulses (range 1..6).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port y_in  input  1  pulse stream from the upstream sequence-detector FSM output.
REQ-007 SHALL have port clear_in  input  1  synchronous clear of count_out and err_out.
REQ-008 SHALL have port count_out  output  CNT_W  number of valid pulses seen, registered.
REQ-009 SHALL have port done_out  output  1  one-cycle strobe per valid pulse, registered.
REQ-010 SHALL have port err_out  output  1  sticky malformed-traffic flag, registered.
REQ-011 SHALL have port busy_out  output  1  high while state is MEAS or GAP, registered.

Function
REQ-012 SHALL sample y_in on every rising clk edge; no combinational path from any input to any output.
REQ-013 SHALL implement states IDLE, MEAS, GAP; 3-bit width counter wcnt and 3-bit gap counter gcnt, both saturating at 7.
REQ-014 IDLE: y_in=1 -> MEAS with wcnt=1; y_in=0 -> stay IDLE.
REQ-015 MEAS: y_in=1 -> stay, wcnt+1 (saturating); y_in=0 -> end-of-pulse edge, evaluate wcnt, go GAP with gcnt=1.
REQ-016 At end-of-pulse edge with wcnt==PULSE_LEN: count_out increments by 1, done_out=1 for exactly the following cycle.
REQ-017 At end-of-pulse edge with wcnt!=PULSE_LEN: count_out unchanged, done_out stays 0, err_out set to 1.
REQ-018 count_out SHALL saturate at 2^CNT_W-1; further valid pulses assert done_out but do not wrap count_out.
REQ-019 GAP: y_in=0 -> gcnt+1; when gcnt reaches MIN_GAP go IDLE on that edge.
REQ-020 GAP: y_in=1 with gcnt<MIN_GAP -> err_out set, go MEAS with wcnt=1 (new pulse still measured and may count).
REQ-021 err_out SHALL remain 1 until reset or clear_in; further errors have no additional effect.
REQ-022 clear_in=1 SHALL, at that edge, set count_out=0, err_out=0, done_out=0; FSM state/counters continue unaffected.
REQ-023 clear_in coincident with a valid end-of-pulse edge: clear wins, count_out=0, done_out stays 0 next cycle.
REQ-024 clear_in coincident with an error event: clear wins, err_out=0.
REQ-025 busy_out SHALL equal (state!=IDLE) as a registered value, i.e. high the cycle after first high sample.

Reset
REQ-026 reset=1 at a rising edge SHALL force state=IDLE, wcnt=0, gcnt=0, count_out=0, done_out=0, err_out=0, busy_out=0.
REQ-027 reset SHALL override clear_in and y_in; a pulse in progress is discarded and not counted or flagged.
REQ-028 After reset deassertion, a y_in already high SHALL be treated as a new pulse start on the first sampled edge.

Verification
REQ-029 y_in: 0,1,1,1,0,0 -> count_out 0->1 at the edge sampling the first 0, done_out=1 one cycle, err_out=0.
REQ-030 Pulse widths 2 then 4 (gap 3) -> count_out=0, done_out never 1, err_out=1 after first pulse end.
REQ-031 Two width-3 pulses separated by 1 low cycle (MIN_GAP=2) -> err_out=1, count_out=2, done_out pulses twice.
REQ-032 CNT_W=2, five valid pulses -> count_out 1,2,3,3,3, done_out asserted five times.
REQ-033 clear_in on the end-of-pulse edge of a valid pulse with count_out=4 -> count_out=0, done_out=0.
REQ-034 reset asserted mid-pulse (after 2 high cycles) then y_in=1 for 3 more cycles after release -> count_out=1, err_out=0.
